// File: rtl/camera_pack_pkg.sv
// Shared types and sizing for the camera pixel-to-AXI-Stream word packer.
package camera_pack_pkg;

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        PACK     = 1'b1
    } packer_state_t;

    localparam int LANES           = 8;
    localparam int PIX_W           = 16;
    localparam int WORD_W          = LANES * PIX_W;
    localparam int WORDS_PER_FRAME = 1280 * 720 / LANES;
    localparam int FIFO_W          = WORD_W + 1;

endpackage

// File: rtl/word_skid_fifo.sv
// Two-entry first-word-fall-through buffer carrying {tlast, data} words.
module word_skid_fifo
    import camera_pack_pkg::*;
#(
    parameter int WIDTH = FIFO_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             valid
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             rd_ptr_reg;
    logic             wr_ptr_reg;
    logic [1:0]       count_reg;
    logic             pop_acc;
    logic             push_acc;

    assign valid    = (count_reg != 2'd0);
    assign full     = (count_reg == 2'd2);
    assign pop_acc  = pop && valid;
    // A pop frees the slot being written, so a push while full is fine if it pops.
    assign push_acc = push && (!full || pop_acc);
    assign rdata    = valid ? mem_reg[rd_ptr_reg] : '0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_reg[0] <= '0;
            mem_reg[1] <= '0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_acc) begin
                mem_reg[wr_ptr_reg] <= wdata;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop_acc) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_acc, pop_acc})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/camera_word_packer.sv
// Packs frame-aligned RGB565 pixels eight at a time into 128-bit AXI-Stream
// words, marking the last word of each frame and dropping frames on overflow.
module camera_word_packer #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int PIX_W    = camera_pack_pkg::PIX_W,
    parameter int LANES    = camera_pack_pkg::LANES
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   pixel_valid_in,
    input  logic [PIX_W-1:0]       pixel_data_in,
    input  logic [10:0]            pixel_hcount_in,
    input  logic [9:0]             pixel_vcount_in,
    output logic [PIX_W*LANES-1:0] axis_data_out,
    output logic                   axis_tlast_out,
    output logic                   axis_valid_out,
    input  logic                   axis_ready_in,
    output logic                   frame_drop_out
);
    import camera_pack_pkg::*;

    localparam int DATA_W     = PIX_W * LANES;
    localparam int WORDS      = H_ACTIVE * V_ACTIVE / LANES;
    localparam int WORD_CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(WORDS - 1);

    packer_state_t                 state_reg, state_next;
    logic [LANE_W-1:0]             lane_cnt_reg, lane_cnt_next;
    logic [WORD_CNT_W-1:0]         word_cnt_reg, word_cnt_next;
    logic [LANES-1:0][PIX_W-1:0]   asm_reg, asm_next;
    logic                          drop_reg, drop_next;

    logic [LANES-1:0][PIX_W-1:0]   merged;
    logic                          is_sof;
    logic                          last_word;
    logic                          word_done;
    logic                          fifo_push;
    logic                          fifo_pop;
    logic                          fifo_full;
    logic                          fifo_valid;
    logic                          overflow;
    logic [DATA_W:0]               fifo_wdata;
    logic [DATA_W:0]               fifo_rdata;

    assign is_sof    = pixel_valid_in && (pixel_hcount_in == 11'd0) && (pixel_vcount_in == 10'd0);
    assign last_word = (word_cnt_reg == LAST_WORD);
    assign word_done = (lane_cnt_reg == LAST_LANE);
    assign fifo_pop  = fifo_valid && axis_ready_in;
    assign overflow  = fifo_push && fifo_full && !fifo_pop;

    // Current assembly with the incoming pixel dropped into its lane.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign merged[gi] = (lane_cnt_reg == LANE_W'(gi)) ? pixel_data_in : asm_reg[gi];
        end
    endgenerate

    assign fifo_wdata = {last_word, merged};

    always_comb begin
        state_next    = state_reg;
        lane_cnt_next = lane_cnt_reg;
        word_cnt_next = word_cnt_reg;
        asm_next      = asm_reg;
        drop_next     = 1'b0;
        fifo_push     = 1'b0;
        case (state_reg)
            WAIT_SOF: begin
                if (is_sof) begin
                    asm_next[0]   = pixel_data_in;
                    lane_cnt_next = LANE_W'(1);
                    word_cnt_next = '0;
                    state_next    = PACK;
                end
            end
            PACK: begin
                if (is_sof && ((lane_cnt_reg != '0) || (word_cnt_reg != '0))) begin
                    // Truncated frame: abandon the partial word and restart here.
                    asm_next[0]   = pixel_data_in;
                    lane_cnt_next = LANE_W'(1);
                    word_cnt_next = '0;
                    drop_next     = 1'b1;
                end else if (pixel_valid_in) begin
                    asm_next = merged;
                    if (word_done) begin
                        fifo_push = 1'b1;
                        lane_cnt_next = '0;
                        if (overflow) begin
                            word_cnt_next = '0;
                            drop_next     = 1'b1;
                            state_next    = WAIT_SOF;
                        end else begin
                            word_cnt_next = last_word ? '0 : word_cnt_reg + 1'b1;
                        end
                    end else begin
                        lane_cnt_next = lane_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= WAIT_SOF;
            lane_cnt_reg <= '0;
            word_cnt_reg <= '0;
            asm_reg      <= '0;
            drop_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lane_cnt_reg <= lane_cnt_next;
            word_cnt_reg <= word_cnt_next;
            asm_reg      <= asm_next;
            drop_reg     <= drop_next;
        end
    end

    word_skid_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (fifo_push && !overflow),
        .wdata  (fifo_wdata),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .valid  (fifo_valid)
    );

    assign axis_valid_out = fifo_valid;
    assign axis_tlast_out = fifo_rdata[DATA_W];
    assign axis_data_out  = fifo_rdata[DATA_W-1:0];
    assign frame_drop_out = drop_reg;

endmodule

// File: doc/camera_word_packer.md
# camera_word_packer

Upstream feeder for the DDR3 traffic generator's write AXI-Stream. Accepts one RGB565 camera pixel per valid cycle with its frame coordinates and packs eight consecutive pixels into one 128-bit word. Frames are aligned to the first pixel (0,0), and TLAST marks the final word of each 1280x720 frame. The camera cannot be stalled, so the block buffers two words and drops a frame cleanly on overflow rather than emitting misaligned data.

## Interface
Parameters:
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.
- PIX_W, 16: bits per pixel.
- LANES, 8: pixels per output word. PIX_W*LANES must equal 128.

Ports (all sampled/driven on clk_in):
- clk_in  input  1  system clock (DDR3 UI clock domain).
- rst_in  input  1  asynchronous, active-high reset.
- pixel_valid_in  input  1  pixel present this cycle.
- pixel_data_in  input  16  RGB565 pixel.
- pixel_hcount_in  input  11  x coordinate, 0..H_ACTIVE-1.
- pixel_vcount_in  input  10  y coordinate, 0..V_ACTIVE-1.
- axis_data_out  output  128  packed word, pixel k in bits [16k+15:16k].
- axis_tlast_out  output  1  last word of frame.
- axis_valid_out  output  1  word available.
- axis_ready_in  input  1  downstream accepts.
- frame_drop_out  output  1  one-cycle pulse when a frame is abandoned.

## Operation
- States: WAIT_SOF and PACK.
- WAIT_SOF:
  - Ignore pixels until a valid pixel at (0,0) arrives.
  - That pixel is packed as lane 0, and the state moves to PACK.
- PACK:
  - Each valid pixel is written into lane lane_cnt, and lane_cnt increments.
  - When lane 7 is written, the assembled word is pushed to the output buffer, lane_cnt returns to 0, and word_cnt increments.
- Word counter:
  - word_cnt counts 0..WORDS-1, where WORDS = H_ACTIVE*V_ACTIVE/LANES = 115200 (17 bits).
  - A word pushed with word_cnt==WORDS-1 carries tlast=1. word_cnt then wraps to 0 and the state stays PACK; the next pixel must be (0,0).
- Early SOF: a valid (0,0) pixel in PACK while lane_cnt!=0 or word_cnt!=0 means a truncated frame.
  - The partial word is discarded and frame_drop_out pulses.
  - The (0,0) pixel restarts packing as lane 0 with word_cnt=0.
  - Words already buffered are still delivered.
- Output buffer: 2-entry first-word-fall-through FIFO of {tlast, data}.
  - A pop occurs on axis_valid_out && axis_ready_in.
  - A push when the buffer is full and no pop occurs that cycle is an overflow. The word is discarded, frame_drop_out pulses, lane_cnt and word_cnt clear, and the state goes to WAIT_SOF.
  - A push while full with a simultaneous pop is accepted.
- Coordinates are used only for (0,0) detection; no other checking.
- Reset (asynchronous):
  - State WAIT_SOF; lane_cnt, word_cnt and the buffer are cleared.
  - axis_valid_out=0, axis_tlast_out=0, axis_data_out=0, frame_drop_out=0.
  - Reset mid-frame discards all buffered data.

## Timing
- Latency: the word appears on axis_* the cycle after its 8th pixel is accepted.
- axis_data_out and axis_tlast_out are stable while axis_valid_out=1 and axis_ready_in=0.
- Sustained throughput is one word per 8 pixels. The buffer absorbs up to 15 cycles of downstream stall before overflow at 1 pixel/cycle.
- frame_drop_out is registered: asserted the cycle after the offending pixel, high for exactly one cycle.
- Back-to-back words: when the buffer holds 2 and a pop occurs, the second word is presented the following cycle.

## Structure
- Package camera_pack_pkg:
  - packer_state_t enum {WAIT_SOF, PACK}.
  - WORDS_PER_FRAME, LANES and PIX_W constants.
- Sub-module word_skid_fifo: 2-entry FWFT buffer, 129 bits wide, with push/pop/full/valid, on the same asynchronous reset.
- Top level holds the FSM, lane/word counters and the assembly register.

## Test plan
- Full frame, ready always high: pixel value = pixel index mod 65536.
  - Expect 115200 words.
  - Word 0 = {16'h0007,...,16'h0000}.
  - tlast only on word 115199.
  - No drops.
- Start mid-frame at (640,100): expect no output until (0,0) arrives, then a normal frame.
- Early SOF: (0,0) injected after 803 pixels.
  - Expect 100 words out, frame_drop_out pulse, then a full 115200-word frame.
- Backpressure: ready held low for 15 pixel cycles, then high; expect no drop and data intact.
  - Hold ready low for 24 cycles: expect drop pulse, WAIT_SOF, and a correct next frame.
- Random ready (50%), two frames: bit-exact compare against a reference model, and check tlast count = 2.
- Assert rst_in asynchronously mid-word: outputs go to 0 immediately; the next (0,0) restarts cleanly.
